klein_cbc: RTL and testbench
============================

KLEIN_CBC -- requirements
Module: klein_cbc

Interface
REQ-001 SHALL have parameter CHAIN_RESET, default 64'h0: reset/idle value of the chaining register.
REQ-002 SHALL have parameter TIMEOUT, default 1023: max cycles waiting on core_oready per phase; 0 disables the timeout.
REQ-003 SHALL have one clock and an asynchronous active-low reset: iclk in 1 (all state on rising edge) and ireset_n in 1.
REQ-004 SHALL have control inputs: istart in 1 (key/IV load pulse) and iencdec in 1 (1 = encrypt, 0 = decrypt).
REQ-005 SHALL have key/IV inputs: ikey in 64 (cipher key) and iiv in 64 (initialisation vector).
REQ-006 SHALL have the input stream: in_valid in 1, in_data in 64, in_ready out 1.
REQ-007 SHALL have the output stream: out_valid out 1, out_data out 64, out_ready in 1.
REQ-008 SHALL have status outputs: obusy out 1 (state != IDLE/READY) and oerror out 1 (sticky core timeout).
REQ-009 SHALL drive core outputs core_iencdec, core_iinit and core_inext (1 bit each) and core_ikey and core_iblock (64 bits each).
REQ-010 SHALL take core inputs core_oready and core_ovalid (1 bit each) and core_oblock (64 bits).

Function
REQ-011 SHALL implement FSM with states IDLE, KINIT, KLO, KHI, READY, NEXT, NLO, NHI, OUT.
REQ-012 SHALL, on istart in IDLE or READY, latch ikey, iencdec and iiv (into chain), clear oerror and go to KINIT; istart SHALL be ignored in all other states.
REQ-013 SHALL assert core_iinit for exactly the one cycle spent in KINIT, then go to KLO.
REQ-014 SHALL advance KLO to KHI on core_oready==0, and KHI to READY on core_oready==1.
REQ-015 SHALL drive in_ready = (state==READY) && !istart; a handshake is in_valid && in_ready.
REQ-016 SHALL, on handshake when encrypting, load blk = in_data ^ chain; when decrypting, load blk = in_data and save in_data to cbuf; then go to NEXT.
REQ-017 SHALL assert core_inext for exactly the one cycle in NEXT; NLO/NHI SHALL wait as KLO/KHI, and NHI SHALL also require core_ovalid==1.
REQ-018 SHALL, on NHI exit, register out_data (encrypt: core_oblock; decrypt: core_oblock ^ chain), update chain (encrypt: core_oblock; decrypt: cbuf), set out_valid and go to OUT.
REQ-019 SHALL hold out_valid and out_data stable in OUT until out_ready==1, then clear out_valid and go to READY.
REQ-020 SHALL drive core_iblock = blk, core_ikey = latched key and core_iencdec = latched mode.
REQ-021 SHALL, if TIMEOUT!=0 and any of KLO/KHI/NLO/NHI lasts TIMEOUT cycles, set oerror, clear out_valid and go to IDLE.
REQ-022 SHALL allow one block in flight only; in_ready SHALL be 0 outside READY.

Reset
REQ-023 SHALL, on ireset_n==0 (async), force state=IDLE, chain=CHAIN_RESET, blk/cbuf/key/out_data=0, mode=0, all outputs 0.
REQ-024 SHALL abandon any in-flight block on reset assertion mid-operation and emit no output for it.

Configuration
REQ-025 SHALL add, when KLEIN_CBC_CNT_EN is defined, output oblk_count out 32: blocks completed since last istart.
REQ-026 SHALL increment oblk_count on each OUT->READY transition, wrap at 2^32-1 -> 0, and clear it on istart and reset.
REQ-027 SHALL, without KLEIN_CBC_CNT_EN, omit the port and counter, leaving all other behaviour unchanged.

Verification
REQ-028 SHALL be verified with a bench core stub: oblock = iblock ^ ikey, which drops oready 1 cycle after init/next and raises oready+ovalid 12 cycles later.
REQ-029 SHALL pass encrypt: key=0F0F0F0F0F0F0F0F, iv=1111111111111111, P0=0 -> 1E1E1E1E1E1E1E1E; then P1=0 -> 1111111111111111.
REQ-030 SHALL pass decrypt: same key/iv, C0=1E1E1E1E1E1E1E1E, C1=1111111111111111 -> 0000000000000000, 0000000000000000.
REQ-031 SHALL pass backpressure: out_ready=0 for 20 cycles -> out_data stable, in_ready=0 throughout, output released on first out_ready=1.
REQ-032 SHALL pass istart and in_valid in the same READY cycle -> no handshake, KINIT entered, chain=new iv.
REQ-033 SHALL pass timeout: stub never raises oready, TIMEOUT=8 -> oerror=1 after 8 cycles in NLO/NHI, state IDLE, obusy=0.
REQ-034 SHALL pass reset mid-NLO -> all outputs 0 immediately; with KLEIN_CBC_CNT_EN, oblk_count=0.

Source files
------------

// File: rtl/klein_cbc.sv
// CBC chaining wrapper around a KLEIN block-cipher core using an init/next handshake.
// Define KLEIN_CBC_CNT_EN to add the oblk_count completed-block counter output.
module klein_cbc #(
  parameter logic [63:0] CHAIN_RESET = 64'h0,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        istart,
  input  logic        iencdec,
  input  logic [63:0] ikey,
  input  logic [63:0] iiv,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        obusy,
  output logic        oerror,
  output logic        core_iencdec,
  output logic        core_iinit,
  output logic        core_inext,
  output logic [63:0] core_ikey,
  output logic [63:0] core_iblock,
  input  logic        core_oready,
  input  logic        core_ovalid,
  input  logic [63:0] core_oblock
`ifdef KLEIN_CBC_CNT_EN
  ,
  output logic [31:0] oblk_count
`endif
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_KINIT = 4'd1;
  localparam logic [3:0] S_KLO   = 4'd2;
  localparam logic [3:0] S_KHI   = 4'd3;
  localparam logic [3:0] S_READY = 4'd4;
  localparam logic [3:0] S_NEXT  = 4'd5;
  localparam logic [3:0] S_NLO   = 4'd6;
  localparam logic [3:0] S_NHI   = 4'd7;
  localparam logic [3:0] S_OUT   = 4'd8;

  localparam logic [31:0] TMO_LAST = TIMEOUT - 1;

  logic [3:0]  state_q, state_d;
  logic [63:0] chain_q, chain_d;
  logic [63:0] blk_q, blk_d;
  logic [63:0] cbuf_q, cbuf_d;
  logic [63:0] key_q, key_d;
  logic        mode_q, mode_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        oerror_q, oerror_d;
  logic [31:0] tmo_q, tmo_d;

  logic start_ok;
  logic wait_st;
  logic tmo_hit;

  assign start_ok = istart && (state_q == S_IDLE || state_q == S_READY);
  assign wait_st  = (state_q == S_KLO) || (state_q == S_KHI) ||
                    (state_q == S_NLO) || (state_q == S_NHI);
  assign tmo_hit  = (TIMEOUT != 0) && wait_st && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    chain_d     = chain_q;
    blk_d       = blk_q;
    cbuf_d      = cbuf_q;
    key_d       = key_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    oerror_d    = oerror_q;
    tmo_d       = '0;
    if (start_ok) begin
      key_d    = ikey;
      mode_d   = iencdec;
      chain_d  = iiv;
      oerror_d = 1'b0;
      state_d  = S_KINIT;
    end else begin
      case (state_q)
        S_KINIT: state_d = S_KLO;
        S_KLO:   if (!core_oready) state_d = S_KHI;
        S_KHI:   if (core_oready) state_d = S_READY;
        S_READY: if (in_valid) begin
          // Decrypt keeps the ciphertext: it becomes the next chaining value.
          blk_d   = mode_q ? (in_data ^ chain_q) : in_data;
          if (!mode_q) cbuf_d = in_data;
          state_d = S_NEXT;
        end
        S_NEXT:  state_d = S_NLO;
        S_NLO:   if (!core_oready) state_d = S_NHI;
        S_NHI:   if (core_oready && core_ovalid) begin
          out_data_d  = mode_q ? core_oblock : (core_oblock ^ chain_q);
          chain_d     = mode_q ? core_oblock : cbuf_q;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
        S_OUT:   if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_READY;
        end
        default: state_d = S_IDLE;
      endcase
      // A legitimate exit on the final allowed cycle takes priority over the timeout.
      if (tmo_hit && (state_d == state_q)) begin
        oerror_d    = 1'b1;
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    end
    if ((TIMEOUT != 0) && wait_st && (state_d == state_q)) tmo_d = tmo_q + 32'd1;
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q     <= S_IDLE;
      chain_q     <= CHAIN_RESET;
      blk_q       <= '0;
      cbuf_q      <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      oerror_q    <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      chain_q     <= chain_d;
      blk_q       <= blk_d;
      cbuf_q      <= cbuf_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      oerror_q    <= oerror_d;
      tmo_q       <= tmo_d;
    end
  end

  assign in_ready     = (state_q == S_READY) && !istart;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign obusy        = (state_q != S_IDLE) && (state_q != S_READY);
  assign oerror       = oerror_q;
  assign core_iencdec = mode_q;
  assign core_iinit   = (state_q == S_KINIT);
  assign core_inext   = (state_q == S_NEXT);
  assign core_ikey    = key_q;
  assign core_iblock  = blk_q;

`ifdef KLEIN_CBC_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n)                          cnt_q <= '0;
    else if (start_ok)                      cnt_q <= '0;
    else if (state_q == S_OUT && out_ready) cnt_q <= cnt_q + 32'd1;
  end

  assign oblk_count = cnt_q;
`endif

endmodule

// File: tb/tb_klein_cbc.sv
// Scoreboard bench for klein_cbc: a stub core (oblock = iblock ^ ikey) behind the wrapper,
// plus a second TIMEOUT=8 instance whose stub never completes a next operation.
`timescale 1ns/1ps
module tb_klein_cbc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iencdec;
  logic [63:0] ikey, iiv, in_data;
  logic        out_ready;

  logic        istart, in_valid, in_ready, out_valid, obusy, oerror;
  logic [63:0] out_data;
  logic        c_encdec, c_init, c_next, c_ready, c_valid;
  logic [63:0] c_key, c_block, c_oblock;

  logic        istart_t, in_valid_t, in_ready_t, out_valid_t, obusy_t, oerror_t;
  logic [63:0] out_data_t;
  logic        ct_encdec, ct_init, ct_next, ct_ready, ct_valid;
  logic [63:0] ct_key, ct_block, ct_oblock;
`ifdef KLEIN_CBC_CNT_EN
  logic [31:0] oblk_count, oblk_count_t;
`endif

  klein_cbc dut (
    .iclk(clk), .ireset_n(rst_n), .istart(istart), .iencdec(iencdec),
    .ikey(ikey), .iiv(iiv), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .obusy(obusy), .oerror(oerror), .core_iencdec(c_encdec), .core_iinit(c_init),
    .core_inext(c_next), .core_ikey(c_key), .core_iblock(c_block),
    .core_oready(c_ready), .core_ovalid(c_valid), .core_oblock(c_oblock)
`ifdef KLEIN_CBC_CNT_EN
    , .oblk_count(oblk_count)
`endif
  );

  klein_cbc #(.TIMEOUT(8)) dut_t (
    .iclk(clk), .ireset_n(rst_n), .istart(istart_t), .iencdec(iencdec),
    .ikey(ikey), .iiv(iiv), .in_valid(in_valid_t), .in_data(in_data), .in_ready(in_ready_t),
    .out_valid(out_valid_t), .out_data(out_data_t), .out_ready(out_ready),
    .obusy(obusy_t), .oerror(oerror_t), .core_iencdec(ct_encdec), .core_iinit(ct_init),
    .core_inext(ct_next), .core_ikey(ct_key), .core_iblock(ct_block),
    .core_oready(ct_ready), .core_ovalid(ct_valid), .core_oblock(ct_oblock)
`ifdef KLEIN_CBC_CNT_EN
    , .oblk_count(oblk_count_t)
`endif
  );

  // Stub core: oready drops one cycle after init/next, ready+valid return 12 cycles later.
  int s_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ready <= 1'b1; c_valid <= 1'b0; s_cnt <= 0; c_oblock <= '0;
    end else if (c_init || c_next) begin
      c_ready <= 1'b0; c_valid <= 1'b0; s_cnt <= 12; c_oblock <= c_block ^ c_key;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin c_ready <= 1'b1; c_valid <= 1'b1; end
    end
  end

  // Hanging stub: key setup completes quickly, a next operation never completes.
  int t_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_ready <= 1'b1; ct_valid <= 1'b0; t_cnt <= 0; ct_oblock <= '0;
    end else if (ct_init) begin
      ct_ready <= 1'b0; ct_valid <= 1'b0; t_cnt <= 3;
    end else if (ct_next) begin
      ct_ready <= 1'b0; ct_valid <= 1'b0; t_cnt <= 0;
    end else if (t_cnt != 0) begin
      t_cnt <= t_cnt - 1;
      if (t_cnt == 1) ct_ready <= 1'b1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_key, m_chain;
  logic        m_enc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        $display("out %h", out_data);
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_obusy"}, 64'(obusy), 64'd0);
    chk({tag, "_oerror"}, 64'(oerror), 64'd0);
    chk({tag, "_core_init"}, 64'(c_init), 64'd0);
    chk({tag, "_core_next"}, 64'(c_next), 64'd0);
    chk({tag, "_core_mode"}, 64'(c_encdec), 64'd0);
    chk({tag, "_core_key"}, c_key, 64'd0);
    chk({tag, "_core_block"}, c_block, 64'd0);
`ifdef KLEIN_CBC_CNT_EN
    chk({tag, "_count"}, 64'(oblk_count), 64'd0);
`endif
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk("wait_ready", 64'(ok), 64'd1);
  endtask

  task automatic do_start(input logic enc, input logic [63:0] k, input logic [63:0] iv);
    iencdec = enc; ikey = k; iiv = iv; istart = 1'b1;
    @(posedge clk); #1;
    istart = 1'b0;
    m_enc = enc; m_key = k; m_chain = iv;
    $display("start enc=%0d key=%h iv=%h", enc, k, iv);
    chk("init_pulse", 64'(c_init), 64'd1);
    chk("obusy_kinit", 64'(obusy), 64'd1);
    chk("core_key", c_key, k);
    chk("core_mode", 64'(c_encdec), 64'(enc));
    @(posedge clk); #1;
    chk("init_single", 64'(c_init), 64'd0);
    wait_ready();
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] exp);
    bit ok = 1'b0;
    in_data = d; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("send_handshake", 64'(ok), 64'd1);
    if (ok) begin
      exp_q.push_back(exp);
      m_chain = m_enc ? exp : d;
      $display("in  %h -> expect %h", d, exp);
    end
  endtask

  task automatic send_m(input logic [63:0] d, output logic [63:0] exp);
    exp = m_enc ? ((d ^ m_chain) ^ m_key) : ((d ^ m_key) ^ m_chain);
    send(d, exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [63:0] KEY = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] IV  = 64'h1111111111111111;

  initial begin
    logic [63:0] e, pt[3], ct[3];
    int n;
    rst_n = 1'b0; istart = 1'b0; istart_t = 1'b0; iencdec = 1'b0;
    ikey = '0; iiv = '0; in_valid = 1'b0; in_valid_t = 1'b0; in_data = '0; out_ready = 1'b1;
    m_key = '0; m_chain = '0; m_enc = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encrypt vectors, then backpressure on a third chained block.
    do_start(1'b1, KEY, IV);
    send(64'h0, 64'h1E1E1E1E1E1E1E1E);
    send(64'h0, 64'h1111111111111111);
    drain();
`ifdef KLEIN_CBC_CNT_EN
    chk("count_enc", 64'(oblk_count), 64'd2);
`endif
    out_ready = 1'b0;
    send_m(64'h0123456789ABCDEF, e);
    n = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", out_data, e);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", 64'(out_valid), 64'd0);
    chk("bp_popped", 64'(exp_q.size()), 64'd0);

    // Decrypt vectors.
    do_start(1'b0, KEY, IV);
    send(64'h1E1E1E1E1E1E1E1E, 64'h0);
    send(64'h1111111111111111, 64'h0);
    drain();
`ifdef KLEIN_CBC_CNT_EN
    chk("count_dec", 64'(oblk_count), 64'd2);
`endif

    // Random round trip: encrypt with the model, then decrypt back to the plaintext.
    m_key = {$urandom, $urandom}; m_chain = {$urandom, $urandom};
    e = m_chain;
    do_start(1'b1, m_key, e);
    for (int i = 0; i < 3; i++) begin
      pt[i] = {$urandom, $urandom};
      send_m(pt[i], ct[i]);
    end
    drain();
    do_start(1'b0, ikey, e);
    for (int i = 0; i < 3; i++) send(ct[i], pt[i]);
    drain();

    // istart and in_valid together in READY: restart wins, no block accepted.
    wait_ready();
    iencdec = 1'b1; ikey = KEY; iiv = 64'hA5A5A5A5_5A5A5A5A;
    istart = 1'b1; in_valid = 1'b1; in_data = 64'hDEADBEEF_00000000;
    #1;
    chk("start_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    istart = 1'b0; in_valid = 1'b0;
    m_enc = 1'b1; m_key = KEY; m_chain = iiv;
    chk("restart_init", 64'(c_init), 64'd1);
    chk("restart_no_block", 64'(exp_q.size()), 64'd0);
    wait_ready();
    send(64'h0, 64'hA5A5A5A5_5A5A5A5A ^ KEY);
    drain();

    // Timeout: entered NEXT at the handshake edge, then NLO, then 8 cycles in NHI.
    iencdec = 1'b1; istart_t = 1'b1;
    @(posedge clk); #1;
    istart_t = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !in_ready_t; i++) begin @(negedge clk); n++; end
    chk("tmo_ready", 64'(in_ready_t), 64'd1);
    @(posedge clk); #1;
    in_valid_t = 1'b1;
    @(posedge clk); #1;
    in_valid_t = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); n++; #1;
      if (oerror_t) break;
    end
    $display("timeout after %0d cycles", n);
    chk("tmo_error", 64'(oerror_t), 64'd1);
    chk("tmo_cycles", 64'(n), 64'd10);
    chk("tmo_obusy", 64'(obusy_t), 64'd0);
    chk("tmo_out_valid", 64'(out_valid_t), 64'd0);
    chk("tmo_in_ready", 64'(in_ready_t), 64'd0);
    istart_t = 1'b1;
    @(posedge clk); #1;
    istart_t = 1'b0;
    chk("tmo_cleared", 64'(oerror_t), 64'd0);

    // Reset while the main instance sits in NLO.
    wait_ready();
    in_data = 64'h5555AAAA5555AAAA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("nlo_busy", 64'(obusy), 64'd1);
    chk("nlo_no_next", 64'(c_next), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_no_out", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
